seg_scan_mux: RTL

- Time-multiplexes a 4-digit hex value onto one shared 7-segment decoder stage.
- Sits directly upstream of the decoder:
  - drives the decoder's w,x,y,z nibble inputs (w = MSB) and its dp input;
  - generates active-low per-digit enables for the board's common-anode digits.
- Adds a one-cycle all-off guard between digits to prevent ghosting.
- Adds frame-synchronous value updates, so a displayed frame never mixes old and new digits.

---
 rtl/seg_pkg.sv | 15 +
 rtl/lz_blank.sv | 20 ++
 rtl/seg_scan_mux.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared encodings for the 7-segment scan multiplexer: FSM states,
// digit count and the all-digits-dark enable pattern.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } seg_state_t;

    localparam int NDIG = 4;

    localparam logic [NDIG-1:0] DIG_OFF = 4'b1111;

endpackage

// File: rtl/lz_blank.sv
// Leading-zero blank mask: digit k (k >= 1) goes dark when it and every
// more significant nibble are zero. Digit 0 always stays visible.
module lz_blank
    import seg_pkg::*;
(
    input  logic [NDIG*4-1:0] shadow,
    input  logic              blank_lz,
    output logic [NDIG-1:0]   blank_mask
);

    always_comb begin
        blank_mask = '0;
        if (blank_lz) begin
            blank_mask[3] = (shadow[15:12] == 4'h0);
            blank_mask[2] = (shadow[15:8]  == 8'h0);
            blank_mask[1] = (shadow[15:4]  == 12'h0);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Scans four hex digits onto one shared 7-segment decoder with an all-off
// guard cycle between digits and frame-synchronous value updates.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        dp_out,
    output logic [3:0]  digit_n,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DIV - 1);

    seg_state_t       state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [CNT_W-1:0] dwell, dwell_nx;
    logic [15:0]      shadow_val, shadow_val_nx;
    logic [3:0]       shadow_dp, shadow_dp_nx;
    logic [15:0]      pend_val, pend_val_nx;
    logic [3:0]       pend_dp, pend_dp_nx;
    logic             pend, pend_nx;
    logic             transfer;

    logic [3:0]       nibble, nibble_nx;
    logic             dp_nx;
    logic [3:0]       digit_nx;
    logic             frame_done_nx;
    logic [3:0]       blank_mask;

    // Blanking is judged on the shadow value that the next cycle will show.
    lz_blank u_lz_blank (
        .shadow     (shadow_val_nx),
        .blank_lz   (blank_lz),
        .blank_mask (blank_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            idx        <= '0;
            dwell      <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            nibble     <= '0;
            dp_out     <= 1'b0;
            digit_n    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            dwell      <= dwell_nx;
            shadow_val <= shadow_val_nx;
            shadow_dp  <= shadow_dp_nx;
            pend_val   <= pend_val_nx;
            pend_dp    <= pend_dp_nx;
            pend       <= pend_nx;
            nibble     <= nibble_nx;
            dp_out     <= dp_nx;
            digit_n    <= digit_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Pending data only reaches the shadow while dark or at a frame boundary.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        dwell_nx      = dwell;
        shadow_val_nx = shadow_val;
        shadow_dp_nx  = shadow_dp;
        pend_val_nx   = pend_val;
        pend_dp_nx    = pend_dp;
        pend_nx       = pend;
        transfer      = 1'b0;

        case (state)
            ST_OFF: begin
                transfer = pend;
                if (en) begin
                    state_nx = ST_DRIVE;
                    idx_nx   = '0;
                    dwell_nx = '0;
                end
            end
            ST_DRIVE: begin
                if (dwell == DWELL_LAST) begin
                    state_nx = ST_GUARD;
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            ST_GUARD: begin
                idx_nx   = idx + 2'd1;
                dwell_nx = '0;
                if (idx == 2'd3) begin
                    transfer = pend;
                    state_nx = en ? ST_DRIVE : ST_OFF;
                end else begin
                    state_nx = ST_DRIVE;
                end
            end
            default: begin
                state_nx = ST_OFF;
                idx_nx   = '0;
                dwell_nx = '0;
            end
        endcase

        if (transfer) begin
            shadow_val_nx = pend_val;
            shadow_dp_nx  = pend_dp;
            pend_nx       = 1'b0;
        end

        // A load on a transfer edge lands in pending after the old contents move.
        if (load) begin
            pend_val_nx = value;
            pend_dp_nx  = dp_in;
            pend_nx     = 1'b1;
        end
    end

    always_comb begin
        nibble_nx     = '0;
        dp_nx         = 1'b0;
        digit_nx      = DIG_OFF;
        frame_done_nx = 1'b0;

        case (state_nx)
            ST_DRIVE: begin
                nibble_nx = shadow_val_nx[{idx_nx, 2'b00} +: 4];
                dp_nx     = shadow_dp_nx[idx_nx];
                digit_nx  = blank_mask[idx_nx] ? DIG_OFF : ~(4'b0001 << idx_nx);
            end
            ST_GUARD: begin
                nibble_nx     = nibble;
                dp_nx         = dp_out;
                frame_done_nx = (idx_nx == 2'd3);
            end
            default: ;
        endcase
    end

    assign {w, x, y, z} = nibble;

endmodule
